tx_mux_param: RTL
=================

# tx_mux_param

Parametrised transmit-side switch. Input words enter a main FIFO and are demultiplexed into NUM_VC virtual-channel FIFOs by a VC field. Each destination's round-robin arbiter then drains them into NUM_DEST destination FIFOs by a destination field. Threshold-based pause flow control runs at every stage, and a control FSM reports init/idle/active/error.

## Interface
- DATA_W, 6: word width.
- NUM_VC, 2: virtual channels; power of two, at least 2.
- NUM_DEST, 2: destinations; power of two, at least 2.
- MAIN_DEPTH, 4: main FIFO depth; power of two.
- VC_DEPTH, 16: per-VC FIFO depth; power of two.
- DEST_DEPTH, 4: per-destination FIFO depth; power of two.
- THR_W, 5: threshold width. Must satisfy 2^THR_W > max depth.

- clk  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- init  in  1  enter INIT and load thresholds.
- push_main  in  1  write data_in into the main FIFO.
- data_in  in  DATA_W  input word.
- main_high  in  THR_W  main FIFO pause threshold.
- vc_high  in  THR_W  pause threshold shared by all VC FIFOs.
- dest_high  in  THR_W  pause threshold shared by all destination FIFOs.
- pop_dest  in  NUM_DEST  per-destination pop.
- data_out_dest  out  NUM_DEST*DATA_W  registered output. Destination d occupies bits [d*DATA_W +: DATA_W].
- valid_dest  out  NUM_DEST  data_out_dest[d] is valid this cycle.
- main_pause  out  1  main FIFO count >= main threshold; upstream must stop pushing.
- idle_out, active_out, error_out  out  1 each  FSM state flags; exactly one is high except in INIT, when all are 0.

## Operation
- Field decode:
  - VC_BITS = clog2(NUM_VC); DEST_BITS = clog2(NUM_DEST).
  - VC index = word[DATA_W-1 -: VC_BITS]; destination = word[DATA_W-1-VC_BITS -: DEST_BITS].
  - VC_BITS + DEST_BITS must be <= DATA_W.
- FIFOs:
  - Show-ahead: head word visible combinationally.
  - Each FIFO keeps a count of 0..DEPTH.
  - Pause = count >= threshold; a threshold of 0 is treated as DEPTH.
- Main to VC:
  - The main head pops only if main is non-empty, its target VC is not paused and not full, and the FSM is not in INIT.
  - That head's VC is pushed in the same edge.
  - Blocking on one VC stalls main (head-of-line). No other VC is inspected.
- VC to destination:
  - Destination d grants one requesting VC per cycle. A VC requests d when it is non-empty, its head targets d, and d is neither paused nor full.
  - Arbitration is round-robin per destination. The pointer moves to grantee+1 mod NUM_VC on a grant and holds otherwise.
  - A VC pops at most once per cycle; it can request only the destination its head targets.
  - Different destinations may be served in parallel by different VCs.
- Destination output: pop_dest[d] on a non-empty FIFO gives data_out_dest[d] and valid_dest[d]=1 on the next cycle. Otherwise valid_dest[d]=0 and data holds.
- Errors:
  - push_main while main is full: the word is dropped.
  - pop_dest[d] while d is empty: no state change to d.
  - Either event moves the FSM to ERROR.
- FSM states: INIT, IDLE, ACTIVE, ERROR.
  - Reset goes to INIT.
  - INIT latches thresholds every cycle while init=1 and leaves to IDLE on the first cycle with init=0.
  - IDLE goes to ACTIVE when any FIFO is non-empty.
  - ACTIVE goes to IDLE when all FIFOs are empty.
  - Any state goes to ERROR on an error event. ERROR is sticky.
  - init=1 in any state goes to INIT, which has priority over error. FIFO contents are preserved.
- Pushes during INIT are accepted into main; internal transfers are frozen.

## Timing
- Reset (asynchronous):
  - All FIFO counts and pointers 0; all RR pointers 0; thresholds 0.
  - valid_dest=0, data_out_dest=0, main_pause=0.
  - State INIT; idle_out=active_out=error_out=0.
- Latency, with push at edge 0 and pop_dest asserted as soon as valid:
  - Edge 1: word in VC.
  - Edge 2: word in destination.
  - Edge 3: pop.
  - Cycle after edge 3: valid_dest=1.
- Throughput:
  - 1 word/cycle through main.
  - Up to min(NUM_VC, NUM_DEST) words/cycle VC to destination.
- Simultaneous push and pop on the same FIFO:
  - Allowed at any occupancy when not full, and also when full if a pop is occurring (count unchanged).
  - Push-while-full on main with a simultaneous pop is accepted, not an error.
- Flags and pause are computed from registered counts, so they update on the cycle after the edge.

## Test plan
- Reset mid-traffic with 3 words in flight -> all counts 0, valid_dest=0, state INIT immediately (asynchronous).
- INIT with thresholds main=3, vc=4, dest=2, then init=0; push 0x05 (VC0, D0) -> after 3 edges, pop_dest=01 gives data_out_dest[0]=0x05, valid_dest=01; state passes IDLE->ACTIVE->IDLE.
- VC0 and VC1 both hold 4 words targeting D0, with D0 drained continuously -> D0 output alternates VC0, VC1, VC0, ... (round-robin), with no duplicated or lost words.
- Same setup with dest_high=2 and no pops -> D0 holds 2 words, both VCs stall; after VC fill, main stalls and main_pause=1 at 3 words.
- push_main on full main with no pop -> word dropped, error_out=1 next cycle; init pulse -> INIT, then IDLE/ACTIVE with data intact.
- NUM_VC=4, NUM_DEST=4, DATA_W=8: words to (VC3,D2) and (VC1,D0) in the same cycle -> both destinations receive their word on the same edge.

Source files
------------

// File: rtl/tx_mux_param.sv
// rtl/tx_mux_param.sv - parametrised VC/destination transmit switch with pause flow control
// Main FIFO -> per-VC FIFOs -> round-robin per destination -> per-destination FIFOs.

module tx_mux_fifo #(
    parameter int DW    = 6,
    parameter int DEPTH = 4,
    parameter int THR_W = 5
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [DW-1:0]    din,
    input  logic [THR_W-1:0] thr,
    output logic [DW-1:0]    head,
    output logic             empty,
    output logic             full,
    output logic             pause
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [THR_W-1:0] w_thr_eff;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign head      = r_mem[r_rd];
    assign w_pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the same edge frees a slot.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign w_thr_eff = (thr == '0) ? THR_W'(DEPTH) : thr;
    assign pause     = (32'(r_count) >= 32'(w_thr_eff));

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
            if (w_pop_ok)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= din;
    end
endmodule

module tx_mux_param #(
    parameter int DATA_W     = 6,
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 2,
    parameter int MAIN_DEPTH = 4,
    parameter int VC_DEPTH   = 16,
    parameter int DEST_DEPTH = 4,
    parameter int THR_W      = 5
) (
    input  logic                         clk,
    input  logic                         RESET,
    input  logic                         init,
    input  logic                         push_main,
    input  logic [DATA_W-1:0]            data_in,
    input  logic [THR_W-1:0]             main_high,
    input  logic [THR_W-1:0]             vc_high,
    input  logic [THR_W-1:0]             dest_high,
    input  logic [NUM_DEST-1:0]          pop_dest,
    output logic [NUM_DEST*DATA_W-1:0]   data_out_dest,
    output logic [NUM_DEST-1:0]          valid_dest,
    output logic                         main_pause,
    output logic                         idle_out,
    output logic                         active_out,
    output logic                         error_out
);
    localparam int VC_BITS   = $clog2(NUM_VC);
    localparam int DEST_BITS = $clog2(NUM_DEST);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [THR_W-1:0]            r_main_thr;
    logic [THR_W-1:0]            r_vc_thr;
    logic [THR_W-1:0]            r_dest_thr;
    logic [VC_BITS-1:0]          r_rr [NUM_DEST];
    logic [NUM_DEST*DATA_W-1:0]  r_data_out;
    logic [NUM_DEST-1:0]         r_valid;

    logic [DATA_W-1:0]   w_main_head;
    logic                w_main_empty;
    logic                w_main_full;
    logic                w_main_pause;
    logic                w_main_pop;
    logic [VC_BITS-1:0]  w_main_vc;
    logic                w_frozen;

    logic [DATA_W-1:0]   w_vc_head [NUM_VC];
    logic [NUM_VC-1:0]   w_vc_empty;
    logic [NUM_VC-1:0]   w_vc_full;
    logic [NUM_VC-1:0]   w_vc_pause;
    logic [NUM_VC-1:0]   w_vc_push;
    logic [NUM_VC-1:0]   w_vc_pop;

    logic [DATA_W-1:0]   w_dest_head [NUM_DEST];
    logic [DATA_W-1:0]   w_dest_din [NUM_DEST];
    logic [NUM_DEST-1:0] w_dest_empty;
    logic [NUM_DEST-1:0] w_dest_full;
    logic [NUM_DEST-1:0] w_dest_pause;
    logic [NUM_DEST-1:0] w_gnt_any;
    logic [VC_BITS-1:0]  w_gnt_vc [NUM_DEST];
    logic [NUM_VC-1:0]   w_req [NUM_DEST];

    logic                w_err;
    logic                w_any;

    assign w_frozen   = (r_state == S_INIT);
    assign w_main_vc  = w_main_head[DATA_W-1 -: VC_BITS];
    // Head-of-line: only the head's own VC is consulted.
    assign w_main_pop = !w_main_empty && !w_vc_pause[w_main_vc] && !w_vc_full[w_main_vc] && !w_frozen;

    always_comb begin
        w_vc_push = '0;
        if (w_main_pop) w_vc_push[w_main_vc] = 1'b1;
    end

    tx_mux_fifo #(.DW(DATA_W), .DEPTH(MAIN_DEPTH), .THR_W(THR_W)) u_main (
        .clk(clk), .RESET(RESET), .push(push_main), .pop(w_main_pop), .din(data_in),
        .thr(r_main_thr), .head(w_main_head), .empty(w_main_empty), .full(w_main_full),
        .pause(w_main_pause)
    );

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        tx_mux_fifo #(.DW(DATA_W), .DEPTH(VC_DEPTH), .THR_W(THR_W)) u_vc (
            .clk(clk), .RESET(RESET), .push(w_vc_push[g]), .pop(w_vc_pop[g]), .din(w_main_head),
            .thr(r_vc_thr), .head(w_vc_head[g]), .empty(w_vc_empty[g]), .full(w_vc_full[g]),
            .pause(w_vc_pause[g])
        );
    end

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
        tx_mux_fifo #(.DW(DATA_W), .DEPTH(DEST_DEPTH), .THR_W(THR_W)) u_dest (
            .clk(clk), .RESET(RESET), .push(w_gnt_any[g]), .pop(pop_dest[g]), .din(w_dest_din[g]),
            .thr(r_dest_thr), .head(w_dest_head[g]), .empty(w_dest_empty[g]), .full(w_dest_full[g]),
            .pause(w_dest_pause[g])
        );
    end

    // Each VC can only request the destination its head targets, so a VC
    // is granted by at most one destination per cycle.
    always_comb begin
        w_vc_pop = '0;
        for (int d = 0; d < NUM_DEST; d++) begin
            w_req[d]      = '0;
            w_gnt_any[d]  = 1'b0;
            w_gnt_vc[d]   = '0;
            w_dest_din[d] = '0;
            for (int v = 0; v < NUM_VC; v++) begin
                w_req[d][v] = !w_vc_empty[v] && !w_frozen && !w_dest_pause[d] && !w_dest_full[d] &&
                              (w_vc_head[v][DATA_W-1-VC_BITS -: DEST_BITS] == DEST_BITS'(d));
            end
            for (int k = 0; k < NUM_VC; k++) begin
                logic [VC_BITS-1:0] w_idx;
                w_idx = r_rr[d] + VC_BITS'(k);
                if (!w_gnt_any[d] && w_req[d][w_idx]) begin
                    w_gnt_any[d] = 1'b1;
                    w_gnt_vc[d]  = w_idx;
                end
            end
            w_dest_din[d] = w_vc_head[w_gnt_vc[d]];
            if (w_gnt_any[d]) w_vc_pop[w_gnt_vc[d]] = 1'b1;
        end
    end

    assign w_err = (push_main && w_main_full && !w_main_pop) || |(pop_dest & w_dest_empty);
    assign w_any = !w_main_empty || !(&w_vc_empty) || !(&w_dest_empty);

    always_comb begin
        w_state_nxt = r_state;
        if (init) begin
            w_state_nxt = S_INIT;
        end else if (w_err) begin
            w_state_nxt = S_ERROR;
        end else begin
            case (r_state)
                S_INIT:   w_state_nxt = S_IDLE;
                S_IDLE:   if (w_any)  w_state_nxt = S_ACTIVE;
                S_ACTIVE: if (!w_any) w_state_nxt = S_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_INIT;
            r_main_thr <= '0;
            r_vc_thr   <= '0;
            r_dest_thr <= '0;
            r_data_out <= '0;
            r_valid    <= '0;
            for (int d = 0; d < NUM_DEST; d++) r_rr[d] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (init) begin
                r_main_thr <= main_high;
                r_vc_thr   <= vc_high;
                r_dest_thr <= dest_high;
            end
            for (int d = 0; d < NUM_DEST; d++) begin
                if (w_gnt_any[d]) r_rr[d] <= w_gnt_vc[d] + VC_BITS'(1);
                r_valid[d] <= pop_dest[d] && !w_dest_empty[d];
                if (pop_dest[d] && !w_dest_empty[d]) r_data_out[d*DATA_W +: DATA_W] <= w_dest_head[d];
            end
        end
    end

    assign data_out_dest = r_data_out;
    assign valid_dest    = r_valid;
    assign main_pause    = w_main_pause;
    assign idle_out      = (r_state == S_IDLE);
    assign active_out    = (r_state == S_ACTIVE);
    assign error_out     = (r_state == S_ERROR);
endmodule
